serial_rx_parity: RTL and testbench
===================================

Name: serial_rx_parity

Overview:
- Parametrised serial-frame receiver with parity and framing checks; the successor to the fixed 4-bit parity-check receiver.
- Sits on the RX line from the team's serial senders and recovers DATA_W-bit words.
- Supports configurable word width, bit period, parity mode and input synchronisation.
- Reports good words, parity errors and framing errors separately, and keeps a saturating error counter.

Parameters:
DATA_W, 4, data bits per frame (1..16)
CLKS_PER_BIT, 1, clk cycles per serial bit (>=1)
PARITY_MODE, 1, 0 = no parity bit, 1 = even, 2 = odd
SYNC_STAGES, 0, flops on RX before use (0..3); 0 = RX used directly
ERR_CNT_W, 8, width of err_count

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
RX  in  1  serial line, idle high
clr_err  in  1  synchronous clear of err_count
data_out  out  DATA_W  last good word, held until next good word
valid_data  out  1  one-cycle pulse: data_out updated with a good word
parity_err  out  1  one-cycle pulse: parity mismatch
frame_err  out  1  one-cycle pulse: stop bit sampled 0
busy  out  1  high whenever state != IDLE
err_count  out  ERR_CNT_W  saturating count of errored frames

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: all outputs 0, state IDLE, synchroniser flops forced to 1.
- Frame format: start (0), DATA_W data bits LSB first, parity bit (omitted when PARITY_MODE=0), stop (1).
- rxs = RX delayed by SYNC_STAGES flops. All timing below refers to rxs.
- HALF = CLKS_PER_BIT/2 (integer division). Bit counter width is clog2(DATA_W+1); cycle counter width is clog2(CLKS_PER_BIT+1).
- IDLE: on the first cycle rxs==0 (cycle t0), go to START. The cycle counter is loaded so that the start bit is sampled at t0+HALF.
- START: at the sample point, rxs==1 means false start -> IDLE with no pulses; otherwise -> DATA.
- DATA: sample every CLKS_PER_BIT cycles and shift in LSB first. After DATA_W samples, go to PAR (PARITY_MODE!=0) or STOP.
- PAR: sample the parity bit. Expected parity is XOR of the data bits for even, inverted for odd.
- STOP: sample the stop bit. On the cycle after the stop sample, evaluate the frame:
  - Stop==1 and parity ok: data_out <= word, valid_data=1, go to IDLE.
  - Parity bad: parity_err=1; data_out unchanged.
  - Stop==0: frame_err=1 and go to BREAK.
  - Both errors: parity_err and frame_err pulse in the same cycle; err_count increments by 1 only.
- BREAK: wait for rxs==1, then go to IDLE. No new start is detected while in BREAK.
- Latency: valid_data is asserted exactly 1 cycle after the stop sample cycle.
- Back-to-back frames: when the stop bit is good, a start bit whose rxs goes 0 in the cycle right after the stop sample is detected (IDLE is re-entered in the pulse cycle and a 0 on rxs in that cycle counts as t0).
- err_count: +1 per errored frame and saturates at all-ones. clr_err takes priority over an increment in the same cycle (result 0).
- RX glitch mid-frame: no resynchronisation; the value is sampled as-is and the parity check catches single-bit flips.
- rst mid-frame: immediate return to IDLE, partial word discarded, no pulses.
- PARITY_MODE=0: parity_err is never asserted.

Test Plan:
- Defaults (DATA_W=4, even, CLKS_PER_BIT=1, SYNC_STAGES=0), RX = 0,1,0,1,0,0,1 (word 5, parity 0) -> data_out=5, valid_data pulses 1 cycle after stop, busy low next cycle, err_count=0.
- Word 15 with data bit 1 inverted on the line -> parity_err pulse, valid_data stays 0, data_out keeps 5, err_count=1.
- Word 9 with stop bit forced to 0 and line held low 3 cycles -> frame_err pulse, busy stays high through BREAK, then IDLE; the next frame (word 3) is received correctly.
- Back-to-back words 12 then 13 with no idle gap -> two valid_data pulses, data_out=12 then 13.
- CLKS_PER_BIT=8, SYNC_STAGES=2, odd parity, DATA_W=8, word 0xA5; also a 2-cycle start glitch -> 0xA5 received; the glitch gives a false start with no pulses.
- err_count saturation with ERR_CNT_W=2: 5 bad frames give a count of 3; clr_err together with a bad frame gives 0. Assert rst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/serial_rx_parity.sv
// Serial-frame receiver: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// Good words, parity errors and framing errors are reported separately; errored frames are counted.
module serial_rx_parity #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_MODE  = 1,
    parameter int SYNC_STAGES  = 0,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_err,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] LOAD_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'((HALF == 0) ? 0 : HALF - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BREAK = 3'd5;

    logic              rxs;
    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              par_bad;
    logic              stop_sample;
    logic              frame_bad;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rxs = RX;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= (sync_q << 1) | SYNC_STAGES'(RX);
                end
            end
            assign rxs = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        par_bad = 1'b0;
        if (PARITY_MODE != 0) begin
            par_bad = ((^shift) ^ par_bit) != (PARITY_MODE == 2);
        end
    end

    assign stop_sample = (state == STOP) && (cnt == '0);
    assign frame_bad   = stop_sample && (par_bad || !rxs);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            valid_data <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            valid_data <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (clr_err) begin
                err_count <= '0;
            end else if (frame_bad && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        bit_cnt <= '0;
                        // With a sub-2-cycle bit period the start bit's sample point is this cycle.
                        if (HALF == 0) begin
                            state <= DATA;
                            cnt   <= LOAD_BIT;
                        end else begin
                            state <= START;
                            cnt   <= LOAD_HALF;
                        end
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            cnt   <= LOAD_BIT;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift   <= (shift >> 1) | (DATA_W'(rxs) << (DATA_W - 1));
                        cnt     <= LOAD_BIT;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY_MODE != 0) ? PAR : STOP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PAR: begin
                    if (cnt == '0) begin
                        par_bit <= rxs;
                        cnt     <= LOAD_BIT;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        parity_err <= par_bad;
                        frame_err  <= !rxs;
                        if (rxs && !par_bad) begin
                            data_out   <= shift;
                            valid_data <= 1'b1;
                        end
                        state <= rxs ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_parity.sv
// Scoreboarded bench for serial_rx_parity: three instances cover the default,
// oversampled/synchronised odd-parity, and narrow error-counter configurations.
module tb_serial_rx_parity;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic rx_a, rx_b, rx_c;
    logic clr_a, clr_b, clr_c;

    logic [3:0] dout_a, dout_c;
    logic [7:0] dout_b;
    logic       vld_a, vld_b, vld_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       busy_a, busy_b, busy_c;
    logic [7:0] ecnt_a, ecnt_b;
    logic [1:0] ecnt_c;

    serial_rx_parity dut_a (
        .clk(clk), .rst(rst_a), .RX(rx_a), .clr_err(clr_a),
        .data_out(dout_a), .valid_data(vld_a), .parity_err(perr_a),
        .frame_err(ferr_a), .busy(busy_a), .err_count(ecnt_a)
    );

    serial_rx_parity #(.DATA_W(8), .CLKS_PER_BIT(8), .PARITY_MODE(2), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst_b), .RX(rx_b), .clr_err(clr_b),
        .data_out(dout_b), .valid_data(vld_b), .parity_err(perr_b),
        .frame_err(ferr_b), .busy(busy_b), .err_count(ecnt_b)
    );

    serial_rx_parity #(.ERR_CNT_W(2)) dut_c (
        .clk(clk), .rst(rst_c), .RX(rx_c), .clr_err(clr_c),
        .data_out(dout_c), .valid_data(vld_c), .parity_err(perr_c),
        .frame_err(ferr_c), .busy(busy_c), .err_count(ecnt_c)
    );

    // kind encodes {valid_data, parity_err, frame_err}
    typedef struct {
        int kind;
        int data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   last_good[3];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vld_a | perr_a | ferr_a) begin
            exp_t e;
            if (q_a.size() == 0) begin
                check("a_unexpected_pulse", {vld_a, perr_a, ferr_a}, 0);
            end else begin
                e = q_a.pop_front();
                check("a_kind", {vld_a, perr_a, ferr_a}, e.kind);
                check("a_data", dout_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (vld_b | perr_b | ferr_b) begin
            exp_t e;
            if (q_b.size() == 0) begin
                check("b_unexpected_pulse", {vld_b, perr_b, ferr_b}, 0);
            end else begin
                e = q_b.pop_front();
                check("b_kind", {vld_b, perr_b, ferr_b}, e.kind);
                check("b_data", dout_b, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (vld_c | perr_c | ferr_c) begin
            exp_t e;
            if (q_c.size() == 0) begin
                check("c_unexpected_pulse", {vld_c, perr_c, ferr_c}, 0);
            end else begin
                e = q_c.pop_front();
                check("c_kind", {vld_c, perr_c, ferr_c}, e.kind);
                check("c_data", dout_c, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int d, input logic v);
        case (d)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic set_clr(input int d, input logic v);
        case (d)
            0:       clr_a = v;
            1:       clr_b = v;
            default: clr_c = v;
        endcase
    endtask

    // Drives one frame; flip inverts data bits on the line, stop_bit sets the stop level.
    // Returns one cycle after the last stop-bit cycle.
    task automatic send(input int d, input int word, input int flip, input logic stop_bit,
                        input logic clr_at_stop);
        int   dw;
        int   cpb;
        int   w;
        logic pb;
        logic pbad;
        exp_t e;
        dw   = (d == 1) ? 8 : 4;
        cpb  = (d == 1) ? 8 : 1;
        w    = word & ((1 << dw) - 1);
        pb   = ^w;
        if (d == 1) pb = ~pb;
        pbad = ^flip;
        e.kind = stop_bit ? (pbad ? 2 : 4) : (pbad ? 3 : 1);
        e.data = (e.kind == 4) ? w : last_good[d];
        if (e.kind == 4) last_good[d] = w;
        case (d)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        set_rx(d, 1'b0);
        repeat (cpb) tick();
        for (int i = 0; i < dw; i++) begin
            set_rx(d, w[i] ^ flip[i]);
            repeat (cpb) tick();
        end
        set_rx(d, pb);
        repeat (cpb) tick();
        set_rx(d, stop_bit);
        if (clr_at_stop) set_clr(d, 1'b1);
        repeat (cpb) tick();
        set_clr(d, 1'b0);
    endtask

    initial begin
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 3; i++) last_good[i] = 0;
        repeat (3) tick();
        check("a_reset", {dout_a, vld_a, perr_a, ferr_a, busy_a, ecnt_a}, 0);
        check("b_reset", {dout_b, vld_b, perr_b, ferr_b, busy_b, ecnt_b}, 0);
        check("c_reset", {dout_c, vld_c, perr_c, ferr_c, busy_c, ecnt_c}, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) tick();

        // Default instance: good word, latency and busy
        send(0, 5, 0, 1'b1, 1'b0);
        check("a_valid_latency", vld_a, 1);
        check("a_busy_in_pulse", busy_a, 0);
        check("a_data5", dout_a, 5);
        tick();
        check("a_valid_one_cycle", vld_a, 0);
        check("a_ecnt0", ecnt_a, 0);

        // Parity error: data bit 1 of word 15 inverted
        send(0, 15, 2, 1'b1, 1'b0);
        check("a_perr", perr_a, 1);
        check("a_no_valid", vld_a, 0);
        tick();
        check("a_ecnt1", ecnt_a, 1);
        check("a_data_kept", dout_a, 5);

        // Framing error, line held low through BREAK
        send(0, 9, 0, 1'b0, 1'b0);
        check("a_ferr", ferr_a, 1);
        check("a_busy_ferr", busy_a, 1);
        repeat (3) begin
            tick();
            check("a_busy_break", busy_a, 1);
        end
        set_rx(0, 1'b1);
        tick();
        check("a_idle_after_break", busy_a, 0);
        check("a_ecnt2", ecnt_a, 2);
        send(0, 3, 0, 1'b1, 1'b0);
        check("a_data3", dout_a, 3);

        // Back-to-back frames with no idle gap
        send(0, 12, 0, 1'b1, 1'b0);
        check("a_data12", dout_a, 12);
        send(0, 13, 0, 1'b1, 1'b0);
        check("a_data13", dout_a, 13);
        repeat (3) tick();

        // Oversampled, synchronised, odd parity
        send(1, 'hA5, 0, 1'b1, 1'b0);
        repeat (6) tick();
        check("b_dataA5", dout_b, 'hA5);
        check("b_ecnt0", ecnt_b, 0);
        set_rx(1, 1'b0);
        repeat (2) tick();
        set_rx(1, 1'b1);
        tick();
        check("b_glitch_detected", busy_b, 1);
        repeat (12) tick();
        check("b_glitch_idle", busy_b, 0);
        check("b_glitch_data_kept", dout_b, 'hA5);
        send(1, 'h3C, 'h10, 1'b1, 1'b0);
        repeat (6) tick();
        check("b_ecnt1", ecnt_b, 1);

        // Narrow error counter: dual error, saturation, clear priority
        send(2, 6, 0, 1'b1, 1'b0);
        send(2, 7, 1, 1'b0, 1'b0);
        check("c_both_pulses", {perr_c, ferr_c}, 3);
        check("c_ecnt_both", ecnt_c, 1);
        set_rx(2, 1'b1);
        repeat (2) tick();
        for (int k = 2; k <= 5; k++) begin
            send(2, k, 4, 1'b1, 1'b0);
            check("c_ecnt_sat", ecnt_c, (k > 3) ? 3 : k);
        end
        send(2, 1, 1, 1'b1, 1'b1);
        check("c_clr_perr", perr_c, 1);
        check("c_clr_wins", ecnt_c, 0);
        tick();

        // Reset mid-frame
        send(2, 2, 1, 1'b1, 1'b0);
        tick();
        check("c_ecnt_pre_rst", ecnt_c, 1);
        set_rx(2, 1'b0); tick();
        set_rx(2, 1'b1); tick();
        set_rx(2, 1'b0); tick();
        check("c_busy_mid", busy_c, 1);
        @(negedge clk);
        rst_c = 1'b1;
        #1;
        check("c_rst_outputs", {dout_c, vld_c, perr_c, ferr_c, busy_c, ecnt_c}, 0);
        last_good[2] = 0;
        tick();
        rst_c = 1'b0;
        set_rx(2, 1'b1);
        repeat (2) tick();
        send(2, 10, 0, 1'b1, 1'b0);
        check("c_data10", dout_c, 10);

        repeat (5) tick();
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        check("c_queue_empty", q_c.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
